evo_stream_engine: RTL and testbench

- Streaming Game-of-Life evolution stage. On each generation tick it raster-scans the current-generation RAM, one read per cycle.
- It keeps two line buffers plus a 3x3 window and writes each cell's next state to the next-generation RAM.
- The top-level RAM mux routes its read and write ports, exactly as for the existing evolution path.
- Cells outside the grid are dead, so the grid edge is a hard boundary.

---
 rtl/evo_pkg.sv | 21 ++
 rtl/evo_line_buffer.sv | 36 +++
 rtl/evo_stream_engine.sv | 215 +++++++++++++++++++++
 tb/tb_evo_stream_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evo_pkg.sv
// Shared state encoding, default grid constants and the Life rule for the
// streaming evolution stage.
package evo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } evo_state_t;

  localparam int DEF_M       = 600;
  localparam int DEF_N       = 800;
  localparam int DEF_COORD_W = 12;
  localparam int DEF_ADDR_W  = 24;

  function automatic logic life_next(input logic centre, input logic [3:0] count);
    return (count == 4'd3) || (centre && (count == 4'd2));
  endfunction

endpackage

// File: rtl/evo_line_buffer.sv
// Two cascaded (P_DEPTH)-bit shift lines: o_row1 is the sample shifted in
// P_DEPTH shifts ago, o_row2 the one shifted in 2*P_DEPTH shifts ago.
module evo_line_buffer #(
  parameter int P_DEPTH = 801
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_shift,
  input  logic i_clear,
  input  logic i_din,
  output logic o_row1,
  output logic o_row2
);

  logic [P_DEPTH-1:0] r_line1;
  logic [P_DEPTH-1:0] r_line2;

  // NOTE: kept in flops rather than a RAM macro because every bit must read as
  // dead after reset and after a one-cycle clear at generation start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line1 <= '0;
      r_line2 <= '0;
    end else if (i_clear) begin
      r_line1 <= '0;
      r_line2 <= '0;
    end else if (i_shift) begin
      r_line1 <= {r_line1[P_DEPTH-2:0], i_din};
      r_line2 <= {r_line2[P_DEPTH-2:0], r_line1[P_DEPTH-1]};
    end
  end

  assign o_row1 = r_line1[P_DEPTH-1];
  assign o_row2 = r_line2[P_DEPTH-1];

endmodule

// File: rtl/evo_stream_engine.sv
// Streaming Game-of-Life generation stage: raster read, 3x3 window, registered
// next-state write. Optional live-cell count output under `EVO_POPCOUNT_EN.
module evo_stream_engine
  import evo_pkg::*;
#(
  parameter int P_PARAM_M = DEF_M,
  parameter int P_PARAM_N = DEF_N,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_val,
  output logic              busy,
  output logic              done
`ifdef EVO_POPCOUNT_EN
  ,
  output logic [ADDR_W-1:0] population
`endif
);

  localparam logic [COORD_W-1:0] L_ROW_LAST = COORD_W'(P_PARAM_M);
  localparam logic [COORD_W-1:0] L_COL_LAST = COORD_W'(P_PARAM_N);

  evo_state_t          r_state;
  evo_state_t          w_state_nxt;
  logic [COORD_W-1:0]  r_row;
  logic [COORD_W-1:0]  r_col;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_wa_next;
  logic                r_drain;
  logic                r_smp_vld;
  logic                r_smp_pad;
  logic                r_smp_eval;
  logic [2:0]          r_win_a;
  logic [2:0]          r_win_b;
  logic                r_wr_en;
  logic                r_wr_val;
  logic                w_start_ok;
  logic                w_in_grid;
  logic                w_scan_end;
  logic                w_sample;
  logic                w_lb_row1;
  logic                w_lb_row2;
  logic [2:0]          w_col_new;
  logic [3:0]          w_count;
  logic                w_next;

  assign w_start_ok = (r_state == IDLE) && start && !clear;
  assign w_in_grid  = (r_row < L_ROW_LAST) && (r_col < L_COL_LAST);
  assign w_scan_end = (r_row == L_ROW_LAST) && (r_col == L_COL_LAST);

  // NOTE: state and all other flops use non-blocking assignments so every
  // process samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (w_start_ok) w_state_nxt = SCAN;
      SCAN: begin
        rd_en = w_in_grid;
        busy  = 1'b1;
        if (w_scan_end) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain) w_state_nxt = FIN;
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // Scan counters; the read address advances only on real reads, so it stays
  // equal to r*N+c without a multiplier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row     <= '0;
      r_col     <= '0;
      r_rd_addr <= '0;
      r_drain   <= 1'b0;
    end else if (w_start_ok) begin
      r_row     <= '0;
      r_col     <= '0;
      r_rd_addr <= '0;
      r_drain   <= 1'b0;
    end else if (r_state == SCAN) begin
      if (rd_en) r_rd_addr <= r_rd_addr + 1'b1;
      if (r_col == L_COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (r_state == DRAIN) begin
      r_drain <= 1'b1;
    end
  end

  assign rd_addr = r_rd_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_smp_vld  <= 1'b0;
      r_smp_pad  <= 1'b0;
      r_smp_eval <= 1'b0;
    end else begin
      r_smp_vld  <= (r_state == SCAN) && !clear;
      r_smp_pad  <= !w_in_grid;
      r_smp_eval <= (r_row != '0) && (r_col != '0);
    end
  end

  assign w_sample = r_smp_vld && !r_smp_pad && rd_data;

  evo_line_buffer #(
    .P_DEPTH (P_PARAM_N + 1)
  ) u_line_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_shift (r_smp_vld),
    .i_clear (w_start_ok),
    .i_din   (w_sample),
    .o_row1  (w_lb_row1),
    .o_row2  (w_lb_row2)
  );

  // Window columns: bit0 = row r-2, bit1 = row r-1, bit2 = row r. The padding
  // column c=N always holds zeros, so it also serves as the left border.
  assign w_col_new = {w_sample, w_lb_row1, w_lb_row2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_a <= '0;
      r_win_b <= '0;
    end else if (w_start_ok) begin
      r_win_a <= '0;
      r_win_b <= '0;
    end else if (r_smp_vld) begin
      r_win_a <= r_win_b;
      r_win_b <= w_col_new;
    end
  end

  assign w_count = {3'b000, r_win_a[0]} + {3'b000, r_win_a[1]} + {3'b000, r_win_a[2]}
                 + {3'b000, r_win_b[0]} + {3'b000, r_win_b[2]}
                 + {3'b000, w_col_new[0]} + {3'b000, w_col_new[1]} + {3'b000, w_col_new[2]};
  assign w_next  = life_next(r_win_b[1], w_count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_val  <= 1'b0;
      r_wr_addr <= '0;
      r_wa_next <= '0;
    end else begin
      r_wr_en <= r_smp_vld && r_smp_eval && !clear;
      if (w_start_ok) begin
        r_wa_next <= '0;
      end else if (r_smp_vld && r_smp_eval) begin
        r_wr_val  <= w_next;
        r_wr_addr <= r_wa_next;
        r_wa_next <= r_wa_next + 1'b1;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_val  = r_wr_val;

`ifdef EVO_POPCOUNT_EN
  logic [ADDR_W-1:0] r_pop_acc;
  logic [ADDR_W-1:0] r_population;
  logic [ADDR_W-1:0] w_pop_acc_nxt;

  assign w_pop_acc_nxt = r_pop_acc + {{(ADDR_W-1){1'b0}}, (r_wr_en & r_wr_val)};

  // Published on entry to FIN so it is visible in the done cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pop_acc    <= '0;
      r_population <= '0;
    end else begin
      if (w_start_ok) r_pop_acc <= '0;
      else            r_pop_acc <= w_pop_acc_nxt;
      if ((r_state == DRAIN) && r_drain && !clear) r_population <= w_pop_acc_nxt;
    end
  end

  assign population = r_population;
`endif

endmodule

// File: tb/tb_evo_stream_engine.sv
// Scoreboard bench for evo_stream_engine: three small grids (5x5, 4x4, 3x4),
// each with its own current-generation RAM model.
module tb_evo_stream_engine;

  localparam int AW = 24;
  localparam int CW = 12;

  typedef struct {
    int addr;
    bit val;
  } wr_exp_t;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] start   = '0;
  logic [2:0] clear   = '0;
  logic [2:0] rd_data = '0;
  wire  [2:0] rd_en, wr_en, wr_val, busy, done;
  wire  [AW-1:0] rd_addr [3];
  wire  [AW-1:0] wr_addr [3];
`ifdef EVO_POPCOUNT_EN
  wire  [AW-1:0] population [3];
`endif

  logic    cur_mem [3][32];
  wr_exp_t exp_q[$];
  int      got_live[$];
  int      exp_live;
  int      checks = 0;
  int      errors = 0;
  int      grid_m [3] = '{5, 4, 3};
  int      grid_n [3] = '{5, 4, 4};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int M = (g == 0) ? 5 : (g == 1) ? 4 : 3;
    localparam int N = (g == 0) ? 5 : 4;
    evo_stream_engine #(
      .P_PARAM_M (M),
      .P_PARAM_N (N),
      .COORD_W   (CW),
      .ADDR_W    (AW)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start[g]),
      .clear   (clear[g]),
      .rd_en   (rd_en[g]),
      .rd_addr (rd_addr[g]),
      .rd_data (rd_data[g]),
      .wr_en   (wr_en[g]),
      .wr_addr (wr_addr[g]),
      .wr_val  (wr_val[g]),
      .busy    (busy[g]),
      .done    (done[g])
`ifdef EVO_POPCOUNT_EN
      ,
      .population (population[g])
`endif
    );
  end

  // Synchronous current-generation RAMs, one-cycle read latency.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++)
      if (rd_en[g]) rd_data[g] <= cur_mem[g][rd_addr[g][4:0]];
  end

  task automatic clear_mem(input int g);
    for (int i = 0; i < 32; i++) cur_mem[g][i] = 1'b0;
  endtask

  // Reference: plain 2-D Life step with dead cells outside the grid.
  task automatic push_expected(input int g);
    int m, n, cnt, rr, cc;
    bit nv, ctr;
    m = grid_m[g];
    n = grid_n[g];
    exp_q.delete();
    exp_live = 0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < m && cc >= 0 && cc < n)
              if (cur_mem[g][rr*n+cc]) cnt++;
          end
        end
        ctr = cur_mem[g][r*n+c];
        nv  = (cnt == 3) || (ctr && cnt == 2);
        exp_q.push_back('{addr: r*n+c, val: nv});
        if (nv) exp_live++;
      end
    end
  endtask

  task automatic run_gen(input int g, input int restart_at, input int clear_at, input string tag);
    int m, n, s, k, n_wr, last_addr;
    bit finished;
    wr_exp_t e;
    m = grid_m[g];
    n = grid_n[g];
    s = (m + 1) * (n + 1);
    push_expected(g);
    got_live.delete();
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    checks++;
    if (busy[g] !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy[g]);
    end
    k = 1; n_wr = 0; last_addr = -1; finished = 1'b0;
    while (!finished && k <= s + 10) begin
      if (wr_en[g] === 1'b1) begin
        n_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_write: addr %0d beyond expected %0d writes", tag, wr_addr[g], m*n);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr[g] !== AW'(e.addr) || wr_val[g] !== e.val) begin
            errors++;
            $display("FAIL %s write: got addr %0d val %b want addr %0d val %b", tag, wr_addr[g], wr_val[g], e.addr, e.val);
          end
        end
        checks++;
        if (int'(wr_addr[g]) <= last_addr) begin
          errors++; $display("FAIL %s monotonic: got addr %0d after %0d", tag, wr_addr[g], last_addr);
        end
        last_addr = int'(wr_addr[g]);
        if (wr_val[g]) got_live.push_back(int'(wr_addr[g]));
      end
      if (k == clear_at + 1) begin
        checks++;
        if ({wr_en[g], busy[g], done[g]} !== 3'b000) begin
          errors++; $display("FAIL %s after_clear: got wr_en/busy/done %b want 000", tag, {wr_en[g], busy[g], done[g]});
        end
        clear[g] = 1'b0;
        finished = 1'b1;
      end else if (done[g] === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (busy[g] !== 1'b0) begin
          errors++; $display("FAIL %s busy_in_done: got %b want 0", tag, busy[g]);
        end
        checks++;
        if (k != s + 3) begin
          errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, k, s + 3);
        end
        checks++;
        if (n_wr != m * n || exp_q.size() != 0) begin
          errors++; $display("FAIL %s write_count: got %0d want %0d", tag, n_wr, m * n);
        end
`ifdef EVO_POPCOUNT_EN
        checks++;
        if (population[g] !== AW'(exp_live)) begin
          errors++; $display("FAIL %s population: got %0d want %0d", tag, population[g], exp_live);
        end
`endif
      end
      if (!finished) begin
        start[g] = (k == restart_at);
        clear[g] = (k == clear_at);
        k++;
        @(negedge clk);
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within %0d cycles, want %0d", tag, s + 10, s + 3);
    end
    start[g] = 1'b0;
    clear[g] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({rd_en[g], wr_en[g], wr_val[g], busy[g], done[g]} !== 5'b0 || rd_addr[g] !== '0 || wr_addr[g] !== '0) begin
        errors++; $display("FAIL reset_state[%0d]: got en/val/busy/done %b", g, {rd_en[g], wr_en[g], wr_val[g], busy[g], done[g]});
      end
`ifdef EVO_POPCOUNT_EN
      checks++;
      if (population[g] !== '0) begin
        errors++; $display("FAIL reset_population[%0d]: got %0d want 0", g, population[g]);
      end
`endif
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_blinker();
    int want[$];
    bit ok;
    clear_mem(0);
    cur_mem[0][11] = 1'b1; cur_mem[0][12] = 1'b1; cur_mem[0][13] = 1'b1;
    run_gen(0, -1, -1, "blinker");
    want = '{7, 12, 17};
    ok = (got_live.size() == want.size());
    if (ok) foreach (want[i]) if (got_live[i] != want[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL blinker_live: got %p want %p", got_live, want);
    end
  endtask

  task automatic test_block();
    int want[$];
    bit ok;
    clear_mem(1);
    cur_mem[1][5] = 1'b1; cur_mem[1][6] = 1'b1; cur_mem[1][9] = 1'b1; cur_mem[1][10] = 1'b1;
    run_gen(1, -1, -1, "block");
    want = '{5, 6, 9, 10};
    ok = (got_live.size() == want.size());
    if (ok) foreach (want[i]) if (got_live[i] != want[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL block_live: got %p want %p", got_live, want);
    end
  endtask

  task automatic test_corner();
    int want[$];
    bit ok;
    clear_mem(2);
    cur_mem[2][0] = 1'b1; cur_mem[2][2] = 1'b1; cur_mem[2][3] = 1'b1; cur_mem[2][7] = 1'b1;
    run_gen(2, -1, -1, "corner");
    want = '{2, 3, 6, 7};
    ok = (got_live.size() == want.size());
    if (ok) foreach (want[i]) if (got_live[i] != want[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL corner_live: got %p want %p", got_live, want);
    end
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 25; i++) cur_mem[0][i] = 1'($urandom_range(0, 1));
      run_gen(0, (rep == 0) ? 10 : -1, -1, "back_to_back");
    end
  endtask

  task automatic test_clear();
    int bad;
`ifdef EVO_POPCOUNT_EN
    logic [AW-1:0] pop_before;
    pop_before = population[0];
`endif
    clear_mem(0);
    cur_mem[0][11] = 1'b1; cur_mem[0][12] = 1'b1; cur_mem[0][13] = 1'b1;
    run_gen(0, -1, 7, "clear");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || wr_en[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL clear_quiet: got %0d active cycles want 0", bad);
    end
`ifdef EVO_POPCOUNT_EN
    checks++;
    if (population[0] !== pop_before) begin
      errors++; $display("FAIL clear_population: got %0d want %0d", population[0], pop_before);
    end
`endif
    exp_q.delete();
    run_gen(0, -1, -1, "after_clear");
  endtask

  task automatic test_reset_mid_scan();
    int bad;
    for (int i = 0; i < 25; i++) cur_mem[0][i] = 1'($urandom_range(0, 1));
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_en[0], wr_en[0], wr_val[0], busy[0], done[0]} !== 5'b0 || rd_addr[0] !== '0 || wr_addr[0] !== '0) begin
      errors++; $display("FAIL reset_mid_scan: got en/val/busy/done %b want 00000", {rd_en[0], wr_en[0], wr_val[0], busy[0], done[0]});
    end
    @(negedge clk) reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ((rd_en | wr_en | busy | done) !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_after_reset: got %0d active cycles want 0", bad);
    end
    run_gen(0, -1, -1, "after_reset");
  endtask

  initial begin
    for (int g = 0; g < 3; g++) clear_mem(g);
    test_reset();
    test_blinker();
    test_block();
    test_corner();
    test_back_to_back();
    test_clear();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
